// File: rtl/prga_pipelined_addcmp.sv
// Pipelined add/subtract/compare unit: one SEG_WIDTH-bit carry segment per stage,
// carry registered between stages, flags derived from the true MSB in the last stage.
module prga_pipelined_addcmp #(
    parameter int WIDTH     = 32,
    parameter int SEG_WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_valid,
    output logic             i_ready,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic [1:0]       i_op,
    input  logic             i_signed,
    output logic             o_valid,
    input  logic             o_ready,
    output logic [WIDTH-1:0] o_y,
    output logic             o_cout,
    output logic             o_ovf,
    output logic             o_cmp
);
    localparam int NUM_SEGS = (WIDTH + SEG_WIDTH - 1) / SEG_WIDTH;
    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_LT  = 2'b10;
    localparam logic [1:0] OP_GE  = 2'b11;

    // Handshake: a beat transfers on i_valid & i_ready, a result on o_valid & o_ready;
    // the whole pipe moves as one (en), so bubbles travel with the data and a stall freezes every stage.
    logic en;
    assign en      = ~o_valid | o_ready;
    assign i_ready = en;

    for (genvar k = 0; k < NUM_SEGS; k++) begin : g_stg
        localparam int LO = k * SEG_WIDTH;
        localparam int HI = (LO + SEG_WIDTH - 1 > WIDTH - 1) ? WIDTH - 1 : LO + SEG_WIDTH - 1;
        localparam int L  = HI - LO + 1;

        logic               v_in, c_in, s_in, bm_in;
        logic [1:0]         op_in;
        logic [WIDTH-1:LO]  a_in, b_in;
        logic [L:0]         seg;
        logic [HI:0]        res_new;

        if (k == 0) begin : g_src
            assign v_in    = i_valid;
            assign c_in    = (i_op != OP_ADD);
            assign a_in    = i_a;
            assign b_in    = (i_op == OP_ADD) ? i_b : ~i_b;
            assign op_in   = i_op;
            assign s_in    = i_signed;
            assign bm_in   = i_b[WIDTH-1];
            assign res_new = seg[L-1:0];
        end else begin : g_src
            assign v_in    = g_stg[k-1].g_reg.v_q;
            assign c_in    = g_stg[k-1].g_reg.c_q;
            assign a_in    = g_stg[k-1].g_reg.a_q;
            assign b_in    = g_stg[k-1].g_reg.b_q;
            assign op_in   = g_stg[k-1].g_reg.op_q;
            assign s_in    = g_stg[k-1].g_reg.s_q;
            assign bm_in   = g_stg[k-1].g_reg.bm_q;
            assign res_new = {seg[L-1:0], g_stg[k-1].g_reg.res_q};
        end

        assign seg = {1'b0, a_in[HI:LO]} + {1'b0, b_in[HI:LO]} + {{L{1'b0}}, c_in};

        if (k < NUM_SEGS - 1) begin : g_reg
            logic                v_q, v_d, c_q, c_d, s_q, s_d, bm_q, bm_d;
            logic [1:0]          op_q, op_d;
            logic [WIDTH-1:HI+1] a_q, a_d, b_q, b_d;
            logic [HI:0]         res_q, res_d;

            always_comb begin
                v_d   = v_q;
                c_d   = c_q;
                s_d   = s_q;
                bm_d  = bm_q;
                op_d  = op_q;
                a_d   = a_q;
                b_d   = b_q;
                res_d = res_q;
                if (en) begin
                    v_d   = v_in;
                    c_d   = seg[L];
                    s_d   = s_in;
                    bm_d  = bm_in;
                    op_d  = op_in;
                    a_d   = a_in[WIDTH-1:HI+1];
                    b_d   = b_in[WIDTH-1:HI+1];
                    res_d = res_new;
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    v_q   <= 1'b0;
                    c_q   <= 1'b0;
                    s_q   <= 1'b0;
                    bm_q  <= 1'b0;
                    op_q  <= 2'b00;
                    a_q   <= '0;
                    b_q   <= '0;
                    res_q <= '0;
                end else begin
                    v_q   <= v_d;
                    c_q   <= c_d;
                    s_q   <= s_d;
                    bm_q  <= bm_d;
                    op_q  <= op_d;
                    a_q   <= a_d;
                    b_q   <= b_d;
                    res_q <= res_d;
                end
            end
        end else begin : g_out
            logic             v_q, v_d, cout_q, cout_d, ovf_q, ovf_d, cmp_q, cmp_d;
            logic [WIDTH-1:0] y_q, y_d;
            logic             cout, c_msb, ext;

            // Carry into the MSB recovered from the MSB sum bit; ext is bit WIDTH of the
            // sign/zero-extended subtraction, i.e. the sign of A-B.
            assign cout  = seg[L];
            assign c_msb = seg[L-1] ^ a_in[WIDTH-1] ^ b_in[WIDTH-1];
            assign ext   = (s_in & a_in[WIDTH-1]) ^ ~(s_in & bm_in) ^ cout;

            always_comb begin
                v_d    = v_q;
                y_d    = y_q;
                cout_d = cout_q;
                ovf_d  = ovf_q;
                cmp_d  = cmp_q;
                if (en) begin
                    v_d    = v_in;
                    y_d    = res_new;
                    cout_d = cout;
                    ovf_d  = 1'b0;
                    cmp_d  = 1'b0;
                    case (op_in)
                        OP_ADD: ovf_d = s_in ? (c_msb ^ cout) : cout;
                        OP_SUB: ovf_d = s_in ? (c_msb ^ cout) : ~cout;
                        OP_LT:  cmp_d = ext;
                        OP_GE:  cmp_d = ~ext;
                        default: ;
                    endcase
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    v_q    <= 1'b0;
                    y_q    <= '0;
                    cout_q <= 1'b0;
                    ovf_q  <= 1'b0;
                    cmp_q  <= 1'b0;
                end else begin
                    v_q    <= v_d;
                    y_q    <= y_d;
                    cout_q <= cout_d;
                    ovf_q  <= ovf_d;
                    cmp_q  <= cmp_d;
                end
            end
        end
    end

    assign o_valid = g_stg[NUM_SEGS-1].g_out.v_q;
    assign o_y     = g_stg[NUM_SEGS-1].g_out.y_q;
    assign o_cout  = g_stg[NUM_SEGS-1].g_out.cout_q;
    assign o_ovf   = g_stg[NUM_SEGS-1].g_out.ovf_q;
    assign o_cmp   = g_stg[NUM_SEGS-1].g_out.cmp_q;

endmodule

// File: tb/tb_prga_pipelined_addcmp.sv
// Bench for prga_pipelined_addcmp: a 32/8 instance and a 20/8 instance, each scored
// against an arithmetic reference model through an expected-result queue.
module tb_prga_pipelined_addcmp;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        v32, v20, o_ready, i_signed;
  logic [1:0]  i_op;
  logic [31:0] i_a, i_b;
  logic        rdy32, ov32, cout32, ovf32, cmp32;
  logic [31:0] y32;
  logic        rdy20, ov20, cout20, ovf20, cmp20;
  logic [19:0] y20;

  int n_tests = 0;
  int n_fail  = 0;
  logic [34:0] exp32_q[$];
  logic [34:0] exp20_q[$];

  prga_pipelined_addcmp #(.WIDTH(32), .SEG_WIDTH(8)) dut32 (
    .clk(clk), .rst_n(rst_n), .i_valid(v32), .i_ready(rdy32), .i_a(i_a), .i_b(i_b),
    .i_op(i_op), .i_signed(i_signed), .o_valid(ov32), .o_ready(o_ready), .o_y(y32),
    .o_cout(cout32), .o_ovf(ovf32), .o_cmp(cmp32)
  );

  prga_pipelined_addcmp #(.WIDTH(20), .SEG_WIDTH(8)) dut20 (
    .clk(clk), .rst_n(rst_n), .i_valid(v20), .i_ready(rdy20), .i_a(i_a[19:0]), .i_b(i_b[19:0]),
    .i_op(i_op), .i_signed(i_signed), .o_valid(ov20), .o_ready(o_ready), .o_y(y20),
    .o_cout(cout20), .o_ovf(ovf20), .o_cmp(cmp20)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: plain integer arithmetic on w-bit values; returns {cmp, ovf, cout, y}.
  function automatic logic [34:0] model(input int w, input logic [31:0] a, input logic [31:0] b,
                                        input logic [1:0] op, input logic sgn);
    longint mask, ua, ub, sa, sb, full, res, lo, hi;
    logic cout, ovf, cmp;
    logic [31:0] y;
    mask = (longint'(1) << w) - 1;
    ua   = longint'(a) & mask;
    ub   = longint'(b) & mask;
    sa   = ((ua >> (w - 1)) != 0) ? ua - (mask + 1) : ua;
    sb   = ((ub >> (w - 1)) != 0) ? ub - (mask + 1) : ub;
    lo   = -(longint'(1) << (w - 1));
    hi   = (longint'(1) << (w - 1)) - 1;
    cmp  = 1'b0;
    ovf  = 1'b0;
    if (op == 2'b00) begin
      full = ua + ub;
      res  = sa + sb;
      ovf  = sgn ? (res < lo || res > hi) : (full > mask);
    end else begin
      full = ua + ((~ub) & mask) + 1;
      res  = sa - sb;
      if (op == 2'b01) ovf = sgn ? (res < lo || res > hi) : (ua < ub);
      if (op == 2'b10) cmp = sgn ? (sa < sb) : (ua < ub);
      if (op == 2'b11) cmp = sgn ? (sa >= sb) : (ua >= ub);
    end
    y    = 32'(full & mask);
    cout = ((full >> w) & 1) != 0;
    return {cmp, ovf, cout, y};
  endfunction

  function automatic logic [31:0] rnd_operand();
    case ($urandom_range(0, 4))
      0: return 32'h0000_0000;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  // Scoreboard / monitor, 32-bit instance
  logic        st32 = 1'b0;
  logic [34:0] held32, e32;
  always @(negedge clk) begin
    if (!rst_n) st32 = 1'b0;
    else begin
      if (v32 && rdy32) exp32_q.push_back(model(32, i_a, i_b, i_op, i_signed));
      check("ready32", 64'(rdy32), 64'(!(ov32 && !o_ready)));
      if (st32) check("hold32", 64'({ov32, cmp32, ovf32, cout32, y32}), 64'({1'b1, held32}));
      if (ov32 && o_ready) begin
        check("q32_nonempty", 64'(exp32_q.size() != 0), 64'd1);
        if (exp32_q.size() != 0) begin
          e32 = exp32_q.pop_front();
          check("y32", 64'(y32), 64'(e32[31:0]));
          check("cout32", 64'(cout32), 64'(e32[32]));
          check("ovf32", 64'(ovf32), 64'(e32[33]));
          check("cmp32", 64'(cmp32), 64'(e32[34]));
        end
      end
      st32   = ov32 && !o_ready;
      held32 = {cmp32, ovf32, cout32, y32};
    end
  end

  // Scoreboard / monitor, 20-bit instance
  logic        st20 = 1'b0;
  logic [22:0] held20;
  logic [34:0] e20;
  always @(negedge clk) begin
    if (!rst_n) st20 = 1'b0;
    else begin
      if (v20 && rdy20) exp20_q.push_back(model(20, i_a, i_b, i_op, i_signed));
      check("ready20", 64'(rdy20), 64'(!(ov20 && !o_ready)));
      if (st20) check("hold20", 64'({ov20, cmp20, ovf20, cout20, y20}), 64'({1'b1, held20}));
      if (ov20 && o_ready) begin
        check("q20_nonempty", 64'(exp20_q.size() != 0), 64'd1);
        if (exp20_q.size() != 0) begin
          e20 = exp20_q.pop_front();
          check("y20", 64'(y20), 64'(e20[19:0]));
          check("cout20", 64'(cout20), 64'(e20[32]));
          check("ovf20", 64'(ovf20), 64'(e20[33]));
          check("cmp20", 64'(cmp20), 64'(e20[34]));
        end
      end
      st20   = ov20 && !o_ready;
      held20 = {cmp20, ovf20, cout20, y20};
    end
  end

  // Driver: hold the beat until the selected instance accepts it (bounded).
  task automatic send(input bit sel, input logic [31:0] a, input logic [31:0] b,
                      input logic [1:0] op, input logic sgn);
    int n;
    i_a = a; i_b = b; i_op = op; i_signed = sgn;
    if (sel) v20 = 1'b1; else v32 = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(sel ? rdy20 : rdy32) && n < 200);
    check("send_accept", 64'(sel ? rdy20 : rdy32), 64'd1);
    @(posedge clk); #1;
  endtask

  task automatic idle();
    v32 = 1'b0;
    v20 = 1'b0;
  endtask

  // Counts cycles from the presenting cycle until o_valid rises.
  task automatic wait_out(input bit sel, input int exp_lat, input string tag);
    int n;
    n = 1;
    while (!(sel ? ov20 : ov32) && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    check(tag, 64'(n), 64'(exp_lat));
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp32_q.size() + exp20_q.size()) != 0 && n < 400) begin
      @(posedge clk);
      n++;
    end
    check("drain", 64'(exp32_q.size() + exp20_q.size()), 64'd0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic directed(input bit sel, input logic [31:0] a, input logic [31:0] b,
                          input logic [1:0] op, input logic sgn, input int lat,
                          input logic [31:0] ey, input logic [2:0] eflags, input string tag);
    send(sel, a, b, op, sgn);
    idle();
    wait_out(sel, lat, {tag, "_lat"});
    if (sel) begin
      check({tag, "_y"}, 64'(y20), 64'(ey));
      check({tag, "_flags"}, 64'({cout20, ovf20, cmp20}), 64'(eflags));
    end else begin
      check({tag, "_y"}, 64'(y32), 64'(ey));
      check({tag, "_flags"}, 64'({cout32, ovf32, cmp32}), 64'(eflags));
    end
    drain();
  endtask

  initial begin
    rst_n = 1'b0; v32 = 1'b0; v20 = 1'b0; o_ready = 1'b1;
    i_a = '0; i_b = '0; i_op = 2'b00; i_signed = 1'b0;
    #12;
    check("rst_valid32", 64'(ov32), 64'd0);
    check("rst_out32", 64'({y32, cout32, ovf32, cmp32}), 64'd0);
    check("rst_valid20", 64'(ov20), 64'd0);
    check("rst_out20", 64'({y20, cout20, ovf20, cmp20}), 64'd0);
    check("rst_ready32", 64'(rdy32), 64'd1);
    #5 rst_n = 1'b1;
    @(posedge clk); #1;

    // flags are {cout, ovf, cmp}
    directed(0, 32'hFFFF_FFFF, 32'h1, 2'b00, 1'b0, 4, 32'h0000_0000, 3'b110, "add_u_wrap");
    directed(0, 32'h8000_0000, 32'h1, 2'b01, 1'b1, 4, 32'h7FFF_FFFF, 3'b110, "sub_s_ovf");
    directed(0, 32'h3, 32'h5, 2'b01, 1'b0, 4, 32'hFFFF_FFFE, 3'b010, "sub_u_borrow");
    directed(0, 32'hFFFF_FFFF, 32'h1, 2'b10, 1'b1, 4, 32'hFFFF_FFFE, 3'b101, "lt_s");
    directed(0, 32'hFFFF_FFFF, 32'h1, 2'b10, 1'b0, 4, 32'hFFFF_FFFE, 3'b100, "lt_u");
    directed(0, 32'h1234_5678, 32'h1234_5678, 2'b11, 1'b0, 4, 32'h0, 3'b101, "ge_eq");
    directed(1, 32'h000F_FFFF, 32'h1, 2'b00, 1'b0, 3, 32'h0, 3'b110, "add20_wrap");
    directed(1, 32'h0008_0000, 32'h1, 2'b01, 1'b1, 3, 32'h0007_FFFF, 3'b110, "sub20_s_ovf");

    // Back-to-back random stream with o_ready pattern 1,0,0,1,0,0,...
    fork
      begin
        for (int i = 0; i < 16; i++)
          send(0, rnd_operand(), rnd_operand(), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
        idle();
      end
      begin
        for (int c = 0; c < 120; c++) begin
          @(posedge clk); #1;
          o_ready = (c % 3 == 0);
        end
        o_ready = 1'b1;
      end
    join
    o_ready = 1'b1;
    drain();

    // Random stream on the narrow instance
    for (int i = 0; i < 12; i++)
      send(1, rnd_operand(), rnd_operand(), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
    idle();
    drain();

    // Asynchronous reset with three beats in flight, the oldest stalled at the output
    o_ready = 1'b0;
    for (int i = 0; i < 3; i++)
      send(0, $urandom, $urandom, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
    idle();
    @(posedge clk); #1;
    check("pre_rst_valid", 64'(ov32), 64'd1);
    #3 rst_n = 1'b0;
    #1;
    check("async_rst_valid", 64'(ov32), 64'd0);
    check("async_rst_out", 64'({y32, cout32, ovf32, cmp32}), 64'd0);
    exp32_q.delete();
    #2 rst_n = 1'b1;
    o_ready = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk); #1;
      check("no_stale", 64'(ov32), 64'd0);
    end
    directed(0, 32'h0000_00FF, 32'h0000_0001, 2'b00, 1'b0, 4, 32'h0000_0100, 3'b000, "post_rst");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
